// File: rtl/bus_arbiter_if.sv
// Request, downstream MemoryBus and response signals of bus_arbiter.
// master: the arbiter's view; slave: the surrounding requesters/interconnect.
interface bus_arbiter_if #(
   parameter int NUM_PORTS       = 4,
   parameter int DATA_WIDTH      = 24,
   parameter int ADDRESS_WIDTH   = 32,
   parameter int MASTER_ID_WIDTH = 8
);
   logic [NUM_PORTS*ADDRESS_WIDTH-1:0] reqAddress;
   logic [NUM_PORTS*DATA_WIDTH-1:0]    reqData;
   logic [NUM_PORTS-1:0]               reqWrite;
   logic [NUM_PORTS-1:0]               reqValid;
   logic [NUM_PORTS-1:0]               reqTaken;
   logic [DATA_WIDTH-1:0]              rspData;
   logic [NUM_PORTS-1:0]               rspValid;
   logic [NUM_PORTS-1:0]               rspTaken;
   logic [MASTER_ID_WIDTH-1:0]         msID;
   logic [ADDRESS_WIDTH-1:0]           msAddress;
   logic [DATA_WIDTH-1:0]              msData;
   logic                               msWrite;
   logic                               msValid;
   logic                               msTaken;
   logic [MASTER_ID_WIDTH-1:0]         smID;
   logic [DATA_WIDTH-1:0]              smData;
   logic                               smValid;
   logic                               smTaken;

   modport master (
      input  reqAddress, reqData, reqWrite, reqValid, rspTaken, msTaken, smID, smData, smValid,
      output reqTaken, rspData, rspValid, msID, msAddress, msData, msWrite, msValid, smTaken
   );

   modport slave (
      output reqAddress, reqData, reqWrite, reqValid, rspTaken, msTaken, smID, smData, smValid,
      input  reqTaken, rspData, rspValid, msID, msAddress, msData, msWrite, msValid, smTaken
   );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one MemoryBus master port among NUM_PORTS
// requesters. Requests go through a one-entry output slice with the ID
// rewritten to BASE_ID+port; responses are routed back combinationally by ID.
// Optional: define BUS_ARB_STATS_EN to add per-port saturating grant counters.
module bus_arbiter #(
   parameter int NUM_PORTS       = 4,
   parameter int DATA_WIDTH      = 24,
   parameter int ADDRESS_WIDTH   = 32,
   parameter int MASTER_ID_WIDTH = 8,
   parameter int BASE_ID         = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   bus_arbiter_if.master         bus,
   output logic                  idError
`ifdef BUS_ARB_STATS_EN
   ,
   output logic [NUM_PORTS*16-1:0] grantCount
`endif
);
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [PW-1:0] rrPointer;
   logic [PW-1:0] winner;
   logic          found;
   logic          load;
   logic          grant;

   // Slice may accept when empty or being drained this cycle; no grants in reset.
   assign load  = !bus.msValid || bus.msTaken;
   assign grant = load && found && reset;

   // Circular search for the first requesting port starting at rrPointer.
   always_comb begin
      found  = 1'b0;
      winner = rrPointer;
      for (int k = 0; k < NUM_PORTS; k++) begin
         int j;
         j = int'(rrPointer) + k;
         if (j >= NUM_PORTS) j = j - NUM_PORTS;
         if (!found && bus.reqValid[j]) begin
            found  = 1'b1;
            winner = PW'(j);
         end
      end
   end

   // One-hot accept to the winner only.
   always_comb begin
      bus.reqTaken = '0;
      if (grant) bus.reqTaken[winner] = 1'b1;
   end

   // Output slice and round-robin pointer; reset drops any buffered request.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bus.msValid   <= 1'b0;
         bus.msID      <= '0;
         bus.msAddress <= '0;
         bus.msData    <= '0;
         bus.msWrite   <= 1'b0;
         rrPointer     <= '0;
      end else if (load) begin
         if (found) begin
            bus.msValid   <= 1'b1;
            bus.msID      <= MASTER_ID_WIDTH'(BASE_ID + int'(winner));
            bus.msAddress <= bus.reqAddress[int'(winner)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            bus.msData    <= bus.reqData[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            bus.msWrite   <= bus.reqWrite[winner];
            rrPointer     <= (int'(winner) == NUM_PORTS-1) ? '0 : winner + 1'b1;
         end else begin
            bus.msValid   <= 1'b0;
         end
      end
   end

   // Response routing: in-range IDs go to their port, others are drained.
   int            rspIdx;
   logic          inRange;
   logic [PW-1:0] rspSel;

   always_comb begin
      rspIdx       = int'(bus.smID) - BASE_ID;
      inRange      = (rspIdx >= 0) && (rspIdx < NUM_PORTS);
      rspSel       = rspIdx[PW-1:0];
      bus.rspData  = bus.smData;
      bus.rspValid = '0;
      bus.smTaken  = bus.smValid;
      if (inRange) begin
         bus.rspValid[rspSel] = bus.smValid;
         bus.smTaken          = bus.rspTaken[rspSel];
      end
   end

   // Sticky flag for responses whose ID matches no port.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                        idError <= 1'b0;
      else if (bus.smValid && !inRange)  idError <= 1'b1;
   end

`ifdef BUS_ARB_STATS_EN
   logic [NUM_PORTS-1:0][15:0] cnt;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_stat
      // Per-port grant counter, saturating at all-ones.
      always_ff @(posedge clock or negedge reset) begin
         if (!reset)
            cnt[i] <= '0;
         else if (grant && int'(winner) == i && cnt[i] != 16'hFFFF)
            cnt[i] <= cnt[i] + 16'd1;
      end
   end

   assign grantCount = cnt;
`endif

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one downstream MemoryBus master port between NUM_PORTS requesters (RayMemory instances, pixel writers) using round-robin arbitration.
- Registers the request path in a one-entry output slice.
- Rewrites msID to a per-port ID.
- Routes returning responses back to the requester that owns smID.
- Sits between the requesters and the memory interconnect.

Parameters:
- NUM_PORTS, 4, number of requester ports (2..8)
- DATA_WIDTH, 24, bus data width
- ADDRESS_WIDTH, 32, bus address width
- MASTER_ID_WIDTH, 8, bus ID width
- BASE_ID, 8, port i uses ID BASE_ID+i; BASE_ID+NUM_PORTS-1 must fit MASTER_ID_WIDTH

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset
- reqAddress  in  NUM_PORTS*ADDRESS_WIDTH  per-port request address, port i at slice i
- reqData  in  NUM_PORTS*DATA_WIDTH  per-port write data
- reqWrite  in  NUM_PORTS  per-port write flag
- reqValid  in  NUM_PORTS  per-port request valid
- reqTaken  out  NUM_PORTS  per-port request accepted
- rspData  out  DATA_WIDTH  response data, broadcast to all ports
- rspValid  out  NUM_PORTS  per-port response valid, one-hot or zero
- rspTaken  in  NUM_PORTS  per-port response accept
- msID  out  MASTER_ID_WIDTH  downstream request ID
- msAddress  out  ADDRESS_WIDTH  downstream address
- msData  out  DATA_WIDTH  downstream write data
- msWrite  out  1  downstream write flag
- msValid  out  1  downstream request valid
- msTaken  in  1  downstream accept
- smID  in  MASTER_ID_WIDTH  response ID
- smData  in  DATA_WIDTH  response data
- smValid  in  1  response valid
- smTaken  out  1  response accept
- idError  out  1  sticky: a response arrived with an ID outside the port range

Behaviour:
- Reset (reset=0, async): slice empty; msValid=0; msID, msAddress, msData, msWrite=0; rrPointer=0; idError=0.
- Reset mid-transfer drops any buffered request; requesters must re-issue.
- Handshake: a transfer occurs on a rising clock edge with valid&&taken.
- Valid may not drop until taken.
- Payload is stable while valid.
- Slice load condition: load = !msValid || msTaken (empty, or emptying this cycle).
- Winner selection when load=1: the first port with reqValid set, searching circularly from rrPointer.
- reqTaken[winner]=1 in the same cycle, combinational from reqValid, msValid and msTaken.
- All other reqTaken bits are 0.
- On the next edge the slice captures the winner's address, data and write flag, with msID=BASE_ID+winner and msValid=1.
- After a grant, rrPointer = winner+1 mod NUM_PORTS.
- If load=1 and no reqValid: msValid goes to 0 on the next edge (when taken), rrPointer unchanged.
- Back-to-back: msValid&&msTaken together with a pending request reloads the slice in the same edge. Throughput is 1 per cycle.
- Latency: request accepted at edge n appears on msValid from cycle n+1.
- Fairness: a continuously requesting port waits at most NUM_PORTS-1 grants.
- Response path is combinational, no storage.
  - idx = smID-BASE_ID.
  - If 0 <= idx < NUM_PORTS: rspValid[idx]=smValid, smTaken=rspTaken[idx], rspData=smData.
  - Out-of-range ID: all rspValid=0; smTaken=smValid, so the response is drained; idError set on that edge and held until reset.
- Request and response paths are independent; a simultaneous grant and response are both legal.

Optional Feature:
- Macro: BUS_ARB_STATS_EN.
- With the macro:
  - Adds output grantCount, width NUM_PORTS*16.
  - Per-port saturating 16-bit counter, incremented on each granted request.
  - Held at 16'hFFFF once it reaches that value.
  - Cleared by reset.
- Without the macro: the port and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=0 for 3 cycles with all reqValid=1 -> msValid=0, reqTaken=0, idError=0; then release with msTaken=1 -> first grant to port 0, msID=8 on the next cycle.
- Round robin: NUM_PORTS=4, all reqValid=1 continuously, msTaken=1 -> msID sequence 8,9,10,11,8; one msValid per cycle, no bubbles.
- Backpressure: port 2 only, address 0x100, msTaken=0 for 5 cycles -> msValid held with msAddress=0x100 and msID=10; reqTaken[2] low after the first acceptance; one transfer when msTaken=1.
- Response routing: smID=9, smData=0xABCDEF, smValid=1, rspTaken[1]=0 for 2 cycles then 1 -> rspValid=4'b0010 throughout; smTaken follows rspTaken[1].
- Bad ID: smID=3 with smValid=1 -> rspValid=0, smTaken=1; idError=1 from the next cycle and stays set until reset.
- Stats (BUS_ARB_STATS_EN): port 0 granted 70000 times -> grantCount slice 0 = 16'hFFFF; other slices count exactly.
